// File: rtl/gf180mcu_fd_sc_mcu9t5v0__skidbuf_n.sv
// Falling-edge 2-entry valid/ready skid buffer feeding a dffnq output bank.
// Optional OCC occupancy output enabled by GF180MCU_SKIDBUF_OCCUPANCY_EN.
module gf180mcu_fd_sc_mcu9t5v0__skidbuf_n #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLKN,
   input  logic             RN,
   input  logic [WIDTH-1:0] D,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] Q,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
`ifdef GF180MCU_SKIDBUF_OCCUPANCY_EN
   output logic [1:0]       OCC,
`endif
   input  logic             VDD,
   input  logic             VSS
);

   localparam int unsigned OCC_W = 2;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] skid_data;
   logic [WIDTH-1:0] skid_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             in_fire;
   logic             out_fire;
   logic [OCC_W-1:0] occ_nxt;

   // Power pins carry no function; folded into a deliberately unused net.
   logic unused_pwr;
   assign unused_pwr = VDD ^ VSS;

   // Handshakes use only registered ready/valid, so no comb path OUT_READY->IN_READY.
   assign in_fire  = IN_VALID & IN_READY;
   assign out_fire = OUT_VALID & OUT_READY;

   always_ff @(negedge CLKN or negedge RN) begin
      if (!RN) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      q_nxt     = Q;
      skid_nxt  = skid_data;
      occ_nxt   = OCC_W'(0);
      case (state)
         ST_EMPTY: begin
            if (in_fire) begin
               state_nxt = ST_ONE;
               q_nxt     = D;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               q_nxt = D;
            end else if (in_fire) begin
               state_nxt = ST_FULL;
               skid_nxt  = D;
            end else if (out_fire) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // IN_READY is low here, so only a drain can happen.
            if (out_fire) begin
               state_nxt = ST_ONE;
               q_nxt     = skid_data;
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
         end
      endcase
      case (state_nxt)
         ST_ONE:  occ_nxt = OCC_W'(1);
         ST_FULL: occ_nxt = OCC_W'(2);
         default: occ_nxt = OCC_W'(0);
      endcase
   end

   // Datapath and registered handshake outputs follow the next state.
   always_ff @(negedge CLKN or negedge RN) begin
      if (!RN) begin
         Q         <= WIDTH'(0);
         skid_data <= WIDTH'(0);
         OUT_VALID <= 1'b0;
         IN_READY  <= 1'b1;
      end else begin
         Q         <= q_nxt;
         skid_data <= skid_nxt;
         OUT_VALID <= (state_nxt != ST_EMPTY);
         IN_READY  <= (state_nxt != ST_FULL);
      end
   end

`ifdef GF180MCU_SKIDBUF_OCCUPANCY_EN
   always_ff @(negedge CLKN or negedge RN) begin
      if (!RN) begin
         OCC <= OCC_W'(0);
      end else begin
         OCC <= occ_nxt;
      end
   end
`else
   logic [OCC_W-1:0] unused_occ;
   assign unused_occ = occ_nxt;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__skidbuf_n.sv
// Bench for the falling-edge skid buffer: queue model plus directed literal checks.
module tb_gf180mcu_fd_sc_mcu9t5v0__skidbuf_n;

   localparam int unsigned W = 16;

   logic         clkn;
   logic         rn;
   logic [W-1:0] d;
   logic         iv;
   logic         ir;
   logic [W-1:0] q;
   logic         ov;
   logic         ordy;
`ifdef GF180MCU_SKIDBUF_OCCUPANCY_EN
   logic [1:0]   occ;
`endif

   int total = 0;
   int bad   = 0;
   bit run   = 0;

   // Model: words held in order; Q shows the head, or the last head once drained.
   logic [W-1:0] mq[$];
   logic [W-1:0] mlast = '0;

   gf180mcu_fd_sc_mcu9t5v0__skidbuf_n #(.WIDTH(W)) dut (
      .CLKN(clkn),
      .RN(rn),
      .D(d),
      .IN_VALID(iv),
      .IN_READY(ir),
      .Q(q),
      .OUT_VALID(ov),
      .OUT_READY(ordy),
`ifdef GF180MCU_SKIDBUF_OCCUPANCY_EN
      .OCC(occ),
`endif
      .VDD(1'b1),
      .VSS(1'b0)
   );

   initial clkn = 1'b1;
   always #5 clkn = ~clkn;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against model on every rising edge (mid-cycle of the falling-edge design).
   always @(posedge clkn) begin
      if (run) begin
         chk("out_valid", 32'(ov), 32'(mq.size() > 0));
         chk("in_ready", 32'(ir), 32'(mq.size() < 2));
         chk("q", 32'(q), 32'(mlast));
`ifdef GF180MCU_SKIDBUF_OCCUPANCY_EN
         chk("occ", 32'(occ), 32'(mq.size()));
`endif
      end
   end

   task automatic model_edge();
      bit inf;
      bit outf;
      if (rn) begin
         inf  = iv && (mq.size() < 2);
         outf = (mq.size() > 0) && (ordy === 1'b1);
         if (outf) void'(mq.pop_front());
         if (inf) mq.push_back(d);
         if (mq.size() > 0) mlast = mq[0];
      end
   endtask

   task automatic step(input logic v, input logic [W-1:0] data, input logic r);
      iv   = v;
      d    = data;
      ordy = r;
      @(negedge clkn);
      model_edge();
      @(posedge clkn);
      #1;
   endtask

   task automatic chk_occ(input logic [1:0] exp);
`ifdef GF180MCU_SKIDBUF_OCCUPANCY_EN
      chk("occ_lit", 32'(occ), 32'(exp));
`else
      if (exp > 2'd2) chk("occ_range", 32'(exp), 32'd2);
`endif
   endtask

   initial begin
      rn = 1'b0; iv = 1'b0; ordy = 1'b0; d = '0;
      #12;
      chk("rst_ov", 32'(ov), 32'd0);
      chk("rst_ir", 32'(ir), 32'd1);
      chk("rst_q", 32'(q), 32'd0);
      chk_occ(2'd0);
      @(posedge clkn); #2;
      rn  = 1'b1;
      run = 1;

      // Nothing appears before the first accepted word.
      step(1'b0, 16'hBEEF, 1'b1);
      step(1'b0, 16'hBEEF, 1'b1);
      chk("idle_ov", 32'(ov), 32'd0);
      chk("idle_q", 32'(q), 32'd0);

      // Full-rate streaming 1..4.
      for (int k = 1; k <= 4; k++) begin
         step(1'b1, W'(k), 1'b1);
         chk("stream_q", 32'(q), 32'(k));
         chk("stream_ir", 32'(ir), 32'd1);
         chk("stream_ov", 32'(ov), 32'd1);
      end
      step(1'b0, '0, 1'b1);
      chk("stream_drain_ov", 32'(ov), 32'd0);
      chk_occ(2'd0);

      // Backpressure: fill skid, ignore 33 while full, then drain in order.
      step(1'b1, 16'h0011, 1'b1);
      chk("bp_q11", 32'(q), 32'h11);
      chk_occ(2'd1);
      step(1'b1, 16'h0022, 1'b0);
      chk("bp_full_q", 32'(q), 32'h11);
      chk("bp_full_ir", 32'(ir), 32'd0);
      chk_occ(2'd2);
      step(1'b1, 16'h0033, 1'b0);
      chk("bp_hold_q", 32'(q), 32'h11);
      chk_occ(2'd2);
      step(1'b1, 16'h0033, 1'b1);
      chk("bp_q22", 32'(q), 32'h22);
      chk("bp_ir_back", 32'(ir), 32'd1);
      chk_occ(2'd1);
      step(1'b1, 16'h0033, 1'b1);
      chk("bp_q33", 32'(q), 32'h33);
      step(1'b0, '0, 1'b1);
      chk("bp_end_ov", 32'(ov), 32'd0);
      chk_occ(2'd0);

      // Single word drain: Q keeps the stale word after OUT_VALID falls.
      step(1'b1, 16'h005A, 1'b1);
      chk("drain_q", 32'(q), 32'h5A);
      chk("drain_ov1", 32'(ov), 32'd1);
      step(1'b0, '0, 1'b1);
      chk("drain_ov0", 32'(ov), 32'd0);
      chk("drain_stale_q", 32'(q), 32'h5A);

      // Asynchronous reset mid-transfer discards both entries.
      step(1'b1, 16'h00A5, 1'b0);
      step(1'b1, 16'h00A6, 1'b0);
      iv = 1'b1; d = 16'h00A5;
      #1;
      rn = 1'b0;
      mq.delete();
      mlast = '0;
      #1;
      chk("arst_ov", 32'(ov), 32'd0);
      chk("arst_ir", 32'(ir), 32'd1);
      chk("arst_q", 32'(q), 32'd0);
      chk_occ(2'd0);
      @(negedge clkn);
      @(posedge clkn); #2;
      rn = 1'b1;
      step(1'b0, 16'h00A5, 1'b1);
      chk("post_rst_ov", 32'(ov), 32'd0);

      // Randomized traffic with varying valid/ready density.
      for (int i = 0; i < 10000; i++) begin
         int pv;
         int pr;
         pv = (i / 1000) % 4;
         pr = (i / 700) % 4;
         step(logic'(($urandom % 4) >= pv), W'($urandom), logic'(($urandom % 4) >= pr));
      end
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      chk("final_empty_ov", 32'(ov), 32'd0);

      run = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
